// File: rtl/timed_traffic_controller.sv
// timed_traffic_controller: two-road (N-S / E-W) intersection controller with
// per-road red/yellow/green lamps, tick-driven phase timers, mandatory yellow
// and all-red clearance, and timed / actuated / flash / all-red-hold modes.
// Optional feature macro: PED_REQUEST_EN adds a pedestrian walk phase
// (ped_req input, ped_walk output) inserted after an all-red clearance.
//
// Handshake note: there is no valid/ready traffic here; `tick` is a one-cycle
// strobe and every state/timer update is qualified by it, so the block can be
// paused indefinitely by holding tick low.
module timed_traffic_controller #(
  parameter int TW          = 8,
  parameter int T_GREEN_MIN = 4,
  parameter int T_GREEN_MAX = 12,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1,
  parameter int FLASH_DIV   = 2,
  parameter int T_WALK      = 6
) (
  input  logic       clka,
  input  logic       reseta,
  input  logic       tick,
  input  logic [1:0] mode,
  input  logic       ns_demand,
  input  logic       ew_demand,
`ifdef PED_REQUEST_EN
  input  logic       ped_req,
  output logic       ped_walk,
`endif
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    AR_NS = 3'd0, NS_G = 3'd1, NS_Y = 3'd2, AR_EW = 3'd3,
    EW_G  = 3'd4, EW_Y = 3'd5, FLASH = 3'd6, PED = 3'd7
  } state_t;

  localparam int DUR_MAX = (1 << TW) - 1;

  // Reject durations the timer cannot represent (0 or wider than TW bits).
  if (T_GREEN_MIN < 1 || T_GREEN_MIN > DUR_MAX || T_GREEN_MAX < 1 ||
      T_GREEN_MAX > DUR_MAX || T_YELLOW < 1 || T_YELLOW > DUR_MAX ||
      T_ALLRED < 1 || T_ALLRED > DUR_MAX || FLASH_DIV < 1 ||
      FLASH_DIV > DUR_MAX || T_WALK < 1 || T_WALK > DUR_MAX) begin : g_bad_duration
    $error("timed_traffic_controller: every duration must lie in 1..2^TW-1");
  end

  localparam logic [1:0] MODE_TIMED = 2'b00;
  localparam logic [1:0] MODE_ACT   = 2'b01;
  localparam logic [1:0] MODE_FLASH = 2'b10;

  // Timer thresholds: a phase of D ticks is complete on the tick seen at D-1.
  localparam logic [TW-1:0] GMIN_M1   = TW'(T_GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_M1   = TW'(T_GREEN_MAX - 1);
  localparam logic [TW-1:0] YEL_M1    = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] ALLRED_M1 = TW'(T_ALLRED - 1);
  localparam logic [TW-1:0] FDIV_M1   = TW'(FLASH_DIV - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          flash_q, flash_d;     // 1 = ON half of the flash cycle
  logic          restart;              // clear timer without changing state
  logic          own_dem, opp_dem, run_mode;
  // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
  logic [5:0]    lamp_q, lamp_d;

`ifdef PED_REQUEST_EN
  localparam logic [TW-1:0] WALK_M1 = TW'(T_WALK - 1);
  logic ped_q, ped_d;                  // sticky pedestrian request latch
  logic ped_ew_q, ped_ew_d;            // 1 = E-W green is pending after PED
  logic walk_q;
`endif

  // Next-state, timer and flash-toggle decisions.
  always_comb begin
    state_d  = state_q;
    flash_d  = flash_q;
    restart  = 1'b0;
    run_mode = (mode == MODE_TIMED) || (mode == MODE_ACT);
    own_dem  = (state_q == NS_G) ? ns_demand : ew_demand;
    opp_dem  = (state_q == NS_G) ? ew_demand : ns_demand;
    case (state_q)
      AR_NS, AR_EW: begin
        // >= so that a clearance held saturated in all-red hold releases on
        // the first tick after the mode changes.
        if (tick && cnt_q >= ALLRED_M1) begin
          if (mode == MODE_FLASH) begin
            state_d = FLASH;
          end else if (run_mode) begin
`ifdef PED_REQUEST_EN
            if (ped_q) state_d = PED;
            else
`endif
            state_d = (state_q == AR_NS) ? NS_G : EW_G;
          end
        end
      end
      NS_G, EW_G: begin
        if (tick) begin
          if (mode == MODE_TIMED) begin
            if (cnt_q >= GMAX_M1) state_d = (state_q == NS_G) ? NS_Y : EW_Y;
          end else if (mode == MODE_ACT) begin
            if (cnt_q >= GMIN_M1 && opp_dem && (cnt_q >= GMAX_M1 || !own_dem))
              state_d = (state_q == NS_G) ? NS_Y : EW_Y;
          end else begin
            state_d = (state_q == NS_G) ? NS_Y : EW_Y;
          end
        end
      end
      NS_Y: if (tick && cnt_q >= YEL_M1) state_d = AR_EW;
      EW_Y: if (tick && cnt_q >= YEL_M1) state_d = AR_NS;
      FLASH: begin
        if (tick) begin
          if (mode != MODE_FLASH) begin
            state_d = AR_NS;
          end else if (cnt_q >= FDIV_M1) begin
            flash_d = ~flash_q;
            restart = 1'b1;
          end
        end
      end
`ifdef PED_REQUEST_EN
      PED: if (tick && cnt_q >= WALK_M1) state_d = ped_ew_q ? EW_G : NS_G;
`endif
      default: state_d = AR_NS;
    endcase
    // Flashing always starts on the ON half.
    if (state_d == FLASH && state_q != FLASH) flash_d = 1'b1;
  end

  // Phase timer: cleared on entry, counts ticks, saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || restart) cnt_d = '0;
    else if (tick && !(&cnt_q))        cnt_d = cnt_q + TW'(1);
  end

  // Lamp pattern decoded from the next state so lamps move with `phase`.
  always_comb begin
    lamp_d = 6'b100_100;
    case (state_d)
      NS_G:    lamp_d = 6'b001_100;
      NS_Y:    lamp_d = 6'b010_100;
      EW_G:    lamp_d = 6'b100_001;
      EW_Y:    lamp_d = 6'b100_010;
      FLASH:   lamp_d = flash_d ? 6'b010_100 : 6'b000_000;
      default: lamp_d = 6'b100_100;
    endcase
  end

  // State, timer, flash toggle and lamp registers.
  always_ff @(posedge clka) begin
    if (!reseta) begin
      state_q <= AR_NS;
      cnt_q   <= '0;
      flash_q <= 1'b1;
      lamp_q  <= 6'b100_100;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
      lamp_q  <= lamp_d;
    end
  end

`ifdef PED_REQUEST_EN
  // Request latch clears on PED entry; a request in the same cycle re-arms it.
  always_comb begin
    ped_d    = ped_q | ped_req;
    ped_ew_d = ped_ew_q;
    if (state_d == PED && state_q != PED) begin
      ped_d    = ped_req;
      ped_ew_d = (state_q == AR_EW);
    end
  end

  // Pedestrian latch, pending-road and walk-lamp registers.
  always_ff @(posedge clka) begin
    if (!reseta) begin
      ped_q    <= 1'b0;
      ped_ew_q <= 1'b0;
      walk_q   <= 1'b0;
    end else begin
      ped_q    <= ped_d;
      ped_ew_q <= ped_ew_d;
      walk_q   <= (state_d == PED);
    end
  end

  assign ped_walk = walk_q;
`endif

  assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = lamp_q;
  assign phase = state_q;

endmodule

// File: tb/tb_timed_traffic_controller.sv
// Directed bench for timed_traffic_controller (small test parameters).
// Expected per-cycle {ped_walk, phase, lamps} words are queued as each
// stimulus step is issued and popped one per clock when the outputs are sampled.
module tb_timed_traffic_controller;

  logic       clka = 1'b0;
  logic       reseta;
  logic       tick;
  logic [1:0] mode;
  logic       ns_demand, ew_demand;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic [2:0] phase;
  logic       walk_obs;
`ifdef PED_REQUEST_EN
  logic       ped_req;
  logic       ped_walk;
`endif

  int checks = 0;
  int errors = 0;
  int tick_div = 1;
  int tick_ctr = 0;
  int cyc = 0;
  string cur_tag = "reset";
  logic [9:0] exp_q[$];

  timed_traffic_controller #(
    .TW(4), .T_GREEN_MIN(2), .T_GREEN_MAX(5), .T_YELLOW(2),
    .T_ALLRED(1), .FLASH_DIV(2), .T_WALK(6)
  ) dut (
    .clka(clka), .reseta(reseta), .tick(tick), .mode(mode),
    .ns_demand(ns_demand), .ew_demand(ew_demand),
`ifdef PED_REQUEST_EN
    .ped_req(ped_req), .ped_walk(ped_walk),
`endif
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .phase(phase)
  );

  // Clock and reset-free clock generation.
  always #5 clka = ~clka;

`ifdef PED_REQUEST_EN
  assign walk_obs = ped_walk;
`else
  assign walk_obs = 1'b0;
`endif

  // Lamp table: {walk, phase, ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}.
  function automatic logic [9:0] exp_word(input logic [2:0] ph, input logic fl_on);
    logic [5:0] l;
    case (ph)
      3'd1:    l = 6'b001_100;
      3'd2:    l = 6'b010_100;
      3'd4:    l = 6'b100_001;
      3'd5:    l = 6'b100_010;
      3'd6:    l = fl_on ? 6'b010_100 : 6'b000_000;
      default: l = 6'b100_100;
    endcase
    return {(ph == 3'd7), ph, l};
  endfunction

  // Queue n cycles of an expected phase.
  task automatic push_run(input logic [2:0] ph, input int n, input logic fl_on);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_word(ph, fl_on));
  endtask

  // Advance n clocks, sampling 1 time unit after each edge and comparing.
  task automatic run_cycles(input int n);
    logic [9:0] obs;
    logic [9:0] exp;
    for (int i = 0; i < n; i++) begin
      @(posedge clka);
      #1;
      cyc++;
      obs = {walk_obs, phase, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL %s cycle %0d: observed %h, required a queued expectation", cur_tag, cyc, obs);
      end else begin
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
          errors++;
          $error("FAIL %s cycle %0d: observed %h required %h", cur_tag, cyc, obs, exp);
        end
      end
      checks++;
      assert ((ns_green & ew_green) === 1'b0) else begin
        errors++;
        $error("FAIL %s_both_green cycle %0d: observed %b required 0", cur_tag, cyc, ns_green & ew_green);
      end
      tick_ctr++;
      tick = (((tick_ctr + 1) % tick_div) == 0);
    end
  endtask

  initial begin
    reseta = 1'b0; tick = 1'b1; mode = 2'b00; ns_demand = 1'b0; ew_demand = 1'b0;
`ifdef PED_REQUEST_EN
    ped_req = 1'b0;
`endif
    // Reset held three cycles: all-red, phase 0.
    cur_tag = "reset";
    push_run(3'd0, 3, 1'b1);
    run_cycles(3);

    // Timed mode: 16-cycle cycle, run twice.
    cur_tag = "timed";
    reseta = 1'b1;
    for (int r = 0; r < 2; r++) begin
      push_run(3'd1, 5, 1'b1); push_run(3'd2, 2, 1'b1); push_run(3'd3, 1, 1'b1);
      push_run(3'd4, 5, 1'b1); push_run(3'd5, 2, 1'b1); push_run(3'd0, 1, 1'b1);
    end
    run_cycles(32);

    // Actuated: green rests with no opposing demand.
    cur_tag = "act_rest";
    mode = 2'b01; ns_demand = 1'b1; ew_demand = 1'b0;
    push_run(3'd1, 22, 1'b1);
    run_cycles(22);
    // Opposing demand after saturation ends green at once.
    cur_tag = "act_max_sat";
    ew_demand = 1'b1;
    push_run(3'd2, 2, 1'b1); push_run(3'd3, 1, 1'b1);
    run_cycles(3);
    // E-W green with own demand gone: minimum green only.
    cur_tag = "act_ew_min";
    ew_demand = 1'b0;
    push_run(3'd4, 2, 1'b1); push_run(3'd5, 2, 1'b1); push_run(3'd0, 1, 1'b1);
    push_run(3'd1, 2, 1'b1);
    run_cycles(7);
    // Opposing demand raised at phase_cnt=1 with own demand: 5-tick green.
    cur_tag = "act_ns_max";
    ew_demand = 1'b1;
    push_run(3'd1, 3, 1'b1); push_run(3'd2, 2, 1'b1); push_run(3'd3, 1, 1'b1);
    run_cycles(6);
    cur_tag = "act_ew_max";
    push_run(3'd4, 5, 1'b1); push_run(3'd5, 2, 1'b1); push_run(3'd0, 1, 1'b1);
    run_cycles(8);
    // Own demand dropped: N-S green ends at T_GREEN_MIN.
    cur_tag = "act_ns_min";
    ns_demand = 1'b0;
    push_run(3'd1, 2, 1'b1); push_run(3'd2, 2, 1'b1); push_run(3'd3, 1, 1'b1);
    run_cycles(5);

    // Flash entered from NS_G phase_cnt=2 through full yellow and clearance.
    cur_tag = "to_flash";
    mode = 2'b00;
    push_run(3'd4, 5, 1'b1); push_run(3'd5, 2, 1'b1); push_run(3'd0, 1, 1'b1);
    push_run(3'd1, 3, 1'b1);
    run_cycles(11);
    cur_tag = "flash";
    mode = 2'b10;
    push_run(3'd2, 2, 1'b1); push_run(3'd3, 1, 1'b1);
    for (int r = 0; r < 2; r++) begin
      push_run(3'd6, 2, 1'b1); push_run(3'd6, 2, 1'b0);
    end
    run_cycles(11);
    cur_tag = "flash_exit";
    mode = 2'b00;
    push_run(3'd0, 1, 1'b1); push_run(3'd1, 1, 1'b1);
    run_cycles(2);

    // tick every third cycle: every phase stretches by 3.
    cur_tag = "tick_div3";
    tick_div = 3; tick_ctr = 0; tick = 1'b0;
    push_run(3'd1, 14, 1'b1); push_run(3'd2, 6, 1'b1); push_run(3'd3, 3, 1'b1);
    push_run(3'd4, 15, 1'b1); push_run(3'd5, 3, 1'b1);
    run_cycles(41);
    // Reset in the middle of EW_Y: straight to all-red.
    cur_tag = "reset_mid";
    reseta = 1'b0;
    push_run(3'd0, 1, 1'b1);
    run_cycles(1);
    reseta = 1'b1; tick_div = 1; tick = 1'b1;

    // All-red hold entered from EW_G, released by mode 00.
    cur_tag = "hold";
    push_run(3'd1, 5, 1'b1); push_run(3'd2, 2, 1'b1); push_run(3'd3, 1, 1'b1);
    push_run(3'd4, 2, 1'b1);
    run_cycles(10);
    mode = 2'b11;
    push_run(3'd5, 2, 1'b1); push_run(3'd0, 10, 1'b1);
    run_cycles(12);
    cur_tag = "hold_release";
    mode = 2'b00;
    push_run(3'd1, 1, 1'b1);
    run_cycles(1);

`ifdef PED_REQUEST_EN
    // Pedestrian pulse during NS_G: PED inserted before EW_G, once only.
    cur_tag = "ped";
    ped_req = 1'b1;
    push_run(3'd1, 1, 1'b1);
    run_cycles(1);
    ped_req = 1'b0;
    push_run(3'd1, 3, 1'b1); push_run(3'd2, 2, 1'b1); push_run(3'd3, 1, 1'b1);
    push_run(3'd7, 6, 1'b1); push_run(3'd4, 5, 1'b1); push_run(3'd5, 2, 1'b1);
    push_run(3'd0, 1, 1'b1); push_run(3'd1, 1, 1'b1);
    run_cycles(21);
`endif

    cur_tag = "queue_drained";
    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("FAIL %s: observed %0d left required 0", cur_tag, exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timed_traffic_controller.md
Name: timed_traffic_controller

Overview:
- Parametrised successor to the untimed two-road intersection FSM: same N-S / E-W intersection, now with red/yellow/green lamps per road and internal phase timers.
- Mandatory yellow and all-red clearance; three control modes (fixed-time, sensor-actuated, flash) plus an all-red hold.
- Sits between the intersection prescaler, which supplies `tick`, and the lamp drivers.

Parameters:
- TW, 8: phase-timer width in bits. All durations below must be at least 1 and at most 2^TW-1.
- T_GREEN_MIN, 4: minimum green duration in ticks (actuated mode).
- T_GREEN_MAX, 12: maximum green in actuated mode; fixed green in timed mode.
- T_YELLOW, 3: yellow duration in ticks.
- T_ALLRED, 1: all-red clearance duration in ticks.
- FLASH_DIV, 2: ticks per half-period of flash toggling.
- T_WALK, 6: pedestrian walk duration in ticks. Used only when PED_REQUEST_EN is defined.

Ports:
- clka  in  1  system clock; all logic on its rising edge.
- reseta  in  1  synchronous, active-low reset.
- tick  in  1  timebase strobe; timers advance only on cycles with tick=1.
- mode  in  2  control mode: 00 timed, 01 actuated, 10 flash, 11 all-red hold.
- ns_demand  in  1  N-S vehicle sensor, level-sensitive.
- ew_demand  in  1  E-W vehicle sensor, level-sensitive.
- ns_red, ns_yellow, ns_green  out  1 each  N-S lamps, registered.
- ew_red, ew_yellow, ew_green  out  1 each  E-W lamps, registered.
- phase  out  3  current state code (encoding listed under Behaviour).

Behaviour:
- Reset: when reseta=0 at a clka edge:
  - state goes to AR_NS and phase_cnt to 0.
  - ns_red=1, ew_red=1; all other lamps 0; flash toggle goes to the ON half.
- States and codes:
  - 0 AR_NS: all-red, next is NS_G.
  - 1 NS_G.
  - 2 NS_Y.
  - 3 AR_EW: all-red, next is EW_G.
  - 4 EW_G.
  - 5 EW_Y.
  - 6 FLASH.
  - 7 PED (only with PED_REQUEST_EN).
- Timer:
  - phase_cnt clears to 0 on every state entry.
  - It increments on tick and saturates at 2^TW-1.
  - "done(D)" means tick=1 and phase_cnt==D-1, so a phase of duration D lasts exactly D ticks.
- Lamps:
  - AR_*: both reds on.
  - *_G: that road green, the other road red.
  - *_Y: that road yellow, the other road red.
  - At most one of red/yellow/green per road is ever asserted.
  - Green on both roads at once is illegal and must never occur.
- Lamp latency: lamp outputs are registered from the next state, so lamps change in the same cycle that `phase` changes.
- Transitions:
  - AR_x -> x_G on done(T_ALLRED), but only when mode is 00 or 01.
    - If mode=10 at that point, go to FLASH.
    - If mode=11, remain in AR_x and hold phase_cnt saturated.
  - x_G, timed mode (00): go to x_Y on done(T_GREEN_MAX).
  - x_G, actuated mode (01):
    - Go to x_Y when phase_cnt >= T_GREEN_MIN-1 on a tick AND opposing demand=1 AND (phase_cnt >= T_GREEN_MAX-1 OR own demand=0).
    - With no opposing demand, green rests indefinitely.
  - x_G with mode 10 or 11: go to x_Y at the next tick. Green is never cut straight to red.
  - NS_Y -> AR_EW and EW_Y -> AR_NS on done(T_YELLOW). Yellow always runs its full duration, regardless of mode changes.
  - FLASH:
    - Flash toggle flips every FLASH_DIV ticks.
    - ON half: ns_yellow=1 and ew_red=1. OFF half: all lamps 0.
    - When mode leaves 10, go to AR_NS at the next tick, entered with all-red lamps and a full T_ALLRED.
- Mode changes: mode is sampled every cycle and acted on only at the decision points listed above.
- tick=0: state and phase_cnt hold. Demand inputs are ignored on non-tick cycles.
- Reset asserted mid-phase: immediate return to AR_NS with all-red on the next edge; no yellow is required.

Optional Feature:
- Macro: PED_REQUEST_EN.
- When defined:
  - Adds input ped_req (1 bit) and output ped_walk (1 bit, reset 0).
  - A ped_req pulse sets a sticky latch.
  - When an AR_x completes done(T_ALLRED) with the latch set and mode 00 or 01, the FSM enters PED instead of x_G.
  - In PED: both reds on, ped_walk=1. The latch clears on PED entry.
  - After done(T_WALK), the FSM goes to the x_G that was pending.
  - A ped_req arriving during PED re-arms the latch for the next clearance.
  - In FLASH or all-red hold, the latch holds its value and no PED is entered.
- When not defined:
  - The ports are absent, state 7 is unreachable, and T_WALK is ignored.

Test Plan:
- Common setup: TW=4, T_GREEN_MIN=2, T_GREEN_MAX=5, T_YELLOW=2, T_ALLRED=1, FLASH_DIV=2, tick tied to 1.
- Scenario 1: reseta=0 for 3 cycles, then 1, mode=00 -> both red for 1 cycle, then NS_G for 5, NS_Y for 2, AR_EW for 1, EW_G for 5, EW_Y for 2; the 16-cycle cycle repeats. Both greens are never high together.
- Scenario 2: mode=01, ew_demand=0, ns_demand=1 -> NS_G holds 20+ cycles. Raise ew_demand with ns_demand=1 at NS_G phase_cnt=1 -> NS_Y entered after phase_cnt reaches 4, i.e. 5 ticks of green. Dropping ns_demand earlier ends green at phase_cnt>=1 (T_GREEN_MIN=2 ticks).
- Scenario 3: mode switched to 10 at NS_G phase_cnt=2 -> NS_Y for 2 cycles, AR_EW for 1, then FLASH: ns_yellow toggles 2 on / 2 off with ew_red in step. Mode back to 00 -> AR_NS with all-red for 1 cycle, then NS_G.
- Scenario 4: tick pulsed every 3rd cycle -> every phase length scales by 3. Reseta=0 driven during EW_Y -> next edge gives phase=0 and only the reds on.
- Scenario 5: mode=11 during EW_G -> EW_Y for 2, then AR_NS held indefinitely with both red. Mode=00 -> NS_G on the next tick.
- Scenario 6 (PED_REQUEST_EN): ped_req pulsed during NS_G -> NS_Y, AR_EW, then PED for 6 cycles with ped_walk=1 and both red, then EW_G.
